// File: rtl/morse_pkg.sv
// morse_pkg: definitions shared by the Morse key front end and the
// downstream character decoder.
//   DOT / DASH      : symbol encoding carried on the sym output
//   key_state_t     : symbol timer state machine states
//   *_UNITS         : timing thresholds, in Morse units
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    // Thresholds compared against the 4-bit saturating unit counter.
    localparam logic [3:0] DASH_UNITS     = 4'd2;
    localparam logic [3:0] CHAR_GAP_UNITS = 4'd3;
    localparam logic [3:0] WORD_GAP_UNITS = 4'd7;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        WAIT_WORD,
        HOLD_ABORT
    } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus level debouncer for one raw key.
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   key_in    : raw asynchronous key, 1 = pressed
//   key_level : debounced level; follows a stable key change after
//               2 + DEBOUNCE_CYCLES cycles
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level
);

    localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            key_level <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            // Any sample agreeing with the accepted level restarts the count,
            // so only an unbroken run of the new level flips key_level.
            if (sync2 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_level <= ~key_level;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_key_timer.sv
// morse_key_timer: turns a single raw Morse key into timed symbol events.
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   key_in     : raw key, asynchronous, 1 = pressed
//   sym_valid  : one-cycle strobe, a symbol is complete
//   sym        : 0 = dot, 1 = dash (meaningful with sym_valid)
//   char_done  : one-cycle strobe, character gap reached
//   word_done  : one-cycle strobe, word gap reached
//   abort      : one-cycle strobe, over-long press discards the character
//   sym_count  : symbols in the current character, saturating at 7
//   key_level  : debounced key level
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int UNIT_CYCLES     = 5000000,
    parameter int ABORT_UNITS     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       sym_valid,
    output logic       sym,
    output logic       char_done,
    output logic       word_done,
    output logic       abort,
    output logic [2:0] sym_count,
    output logic       key_level
);

    localparam int PW = ($clog2(UNIT_CYCLES) < 1) ? 1 : $clog2(UNIT_CYCLES);
    localparam logic [PW-1:0] PRE_MAX = PW'(UNIT_CYCLES - 1);
    localparam logic [3:0]    ABORT_U = 4'(ABORT_UNITS);

    logic          key_level_d;
    logic          key_rise;
    logic          key_fall;
    logic          unit_tick;
    logic [PW-1:0] pres;
    logic [3:0]    unit_cnt;
    key_state_t    state;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (key_level)
    );

    assign key_rise  = key_level & ~key_level_d;
    assign key_fall  = ~key_level & key_level_d;
    // An edge restarts timing, so a coincident tick is dropped.
    assign unit_tick = (pres == PRE_MAX) && !(key_rise || key_fall);

    // Unit timer: measures time since the last debounced edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level_d <= 1'b0;
            pres        <= '0;
            unit_cnt    <= '0;
        end else begin
            key_level_d <= key_level;
            if (key_rise || key_fall) begin
                pres     <= '0;
                unit_cnt <= '0;
            end else if (unit_tick) begin
                pres <= '0;
                if (unit_cnt != 4'd15)
                    unit_cnt <= unit_cnt + 4'd1;
            end else begin
                pres <= pres + 1'b1;
            end
        end
    end

    // Symbol state machine. In GAP and WAIT_WORD a rise is tested before
    // the gap threshold, so a press landing on the threshold cycle
    // continues the character instead of closing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sym_valid <= 1'b0;
            sym       <= DOT;
            char_done <= 1'b0;
            word_done <= 1'b0;
            abort     <= 1'b0;
            sym_count <= 3'd0;
        end else begin
            sym_valid <= 1'b0;
            char_done <= 1'b0;
            word_done <= 1'b0;
            abort     <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_rise)
                        state <= PRESS;
                end
                PRESS: begin
                    if (key_fall) begin
                        sym_valid <= 1'b1;
                        sym       <= (unit_cnt < DASH_UNITS) ? DOT : DASH;
                        if (sym_count != 3'd7)
                            sym_count <= sym_count + 3'd1;
                        state <= GAP;
                    end else if (unit_cnt >= ABORT_U) begin
                        abort     <= 1'b1;
                        sym_count <= 3'd0;
                        state     <= HOLD_ABORT;
                    end
                end
                HOLD_ABORT: begin
                    if (key_fall)
                        state <= IDLE;
                end
                GAP: begin
                    if (key_rise) begin
                        state <= PRESS;
                    end else if (unit_cnt >= CHAR_GAP_UNITS) begin
                        char_done <= 1'b1;
                        sym_count <= 3'd0;
                        state     <= WAIT_WORD;
                    end
                end
                WAIT_WORD: begin
                    if (key_rise) begin
                        state <= PRESS;
                    end else if (unit_cnt >= WORD_GAP_UNITS) begin
                        word_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Front-end stage that turns one raw Morse key (push-button) into timed symbol events for the downstream Morse character decoder.
- Synchronises and debounces the key, then measures press and gap durations in "unit" ticks.
- Emits one-cycle strobes: dot/dash symbols, end-of-character and end-of-word.
- Replaces the separate dot and dash buttons and the "done" switch with a single key and real Morse timing.

Parameters:
- DEBOUNCE_CYCLES, default 50000: number of consecutive cycles the synchronised key must hold a level before that level is accepted.
- UNIT_CYCLES, default 5000000: clk cycles per Morse time unit (one dot length).
- ABORT_UNITS, default 12: a press lasting at least this many units aborts the current character.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- key_in  in  1  raw key, asynchronous, 1 = pressed
- sym_valid  out  1  one-cycle strobe: a symbol is complete
- sym  out  1  symbol value, 0 = dot, 1 = dash; valid only while sym_valid = 1
- char_done  out  1  one-cycle strobe: the character gap is reached
- word_done  out  1  one-cycle strobe: the word gap is reached
- abort  out  1  one-cycle strobe: over-long press; the current character is discarded
- sym_count  out  3  symbols in the current character, saturating at 7
- key_level  out  1  debounced key level, for an LED

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge) clears the following:
  - all outputs to 0;
  - the synchroniser, the debounce counter and the unit counter;
  - the state machine to IDLE.
- Reset mid-press or mid-gap drops all pending events.
- Synchroniser: two flip-flops on key_in.
- Debounce:
  - The counter increments while the synchronised level differs from key_level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, key_level toggles and the counter clears.
  - Latency from a stable key change to the key_level change is 2 + DEBOUNCE_CYCLES cycles.
- Unit timer:
  - The prescaler restarts at 0 on every key_level edge.
  - It produces unit_tick every UNIT_CYCLES cycles.
  - unit_cnt is a 4-bit count of unit_ticks since the last edge, saturating at 15.
- State machine (IDLE, PRESS, GAP, WAIT_WORD, HOLD_ABORT):
  - IDLE: on a key_level rise, go to PRESS.
  - PRESS, on a key_level fall:
    - unit_cnt < 2 gives a dot, otherwise a dash.
    - sym_valid pulses in the cycle after the fall is detected.
    - sym_count increments (saturating at 7).
    - Next state is GAP.
  - PRESS, when unit_cnt reaches ABORT_UNITS:
    - abort pulses and sym_count clears to 0.
    - Next state is HOLD_ABORT.
  - HOLD_ABORT: on a key_level fall, go to IDLE with no symbol.
  - GAP:
    - A key_level rise while unit_cnt < 3 goes to PRESS; the symbol belongs to the same character.
    - When unit_cnt reaches 3, char_done pulses once, sym_count clears, and the next state is WAIT_WORD.
  - WAIT_WORD:
    - A key_level rise goes to PRESS as a new character.
    - When unit_cnt reaches 7, word_done pulses once and the next state is IDLE.
- Strobes are mutually exclusive within a cycle; at most one strobe is high per cycle.
- sym_valid and char_done are never asserted in the same cycle.
- Simultaneous events:
  - A unit_tick in the same cycle as a key_level edge is ignored; the edge wins and the prescaler restarts.
  - A rise in the exact cycle the gap reaches 3 units takes the rise: no char_done, and the symbol continues the character.
- char_done never fires with sym_count = 0, because GAP is only entered after a symbol.
- Symbol cap:
  - sym_count holds 7 after 7 symbols in one character.
  - Classification continues; the downstream decoder flags such codes as invalid.

Decomposition:
- Shared package morse_pkg:
  - DOT = 0 and DASH = 1 (shared with the decoder);
  - the state enum;
  - DASH_UNITS = 2, CHAR_GAP_UNITS = 3, WORD_GAP_UNITS = 7.
- One sub-module, key_debounce: synchroniser plus debounce counter, outputs key_level.
- The timer and state machine stay in the top module.

Test Plan (sim: DEBOUNCE_CYCLES = 4, UNIT_CYCLES = 10, ABORT_UNITS = 12):
- Reset: rst held 3 cycles mid-press (key_in = 1) then released with the key low → all outputs 0, no sym_valid, key_level = 0.
- Bounce: key_in toggles every 2 cycles for 20 cycles, then low → key_level stays 0 and no strobes.
- "A": press 10 cycles, gap 10, press 30, then release for 80 → exactly three strobes:
  - sym_valid with sym = 0, then sym_valid with sym = 1;
  - then char_done once ~30 cycles after the second release.
  - Between the two symbols sym_count = 1; after the second symbol sym_count = 2; after char_done sym_count = 0.
- Word gap: after a single dot, key idle 100 cycles → char_done at ~30 cycles and word_done at ~70 cycles after release, each exactly once, then silence.
- Abort: press held 150 cycles → abort pulses once (~120 cycles after press), no sym_valid on release, sym_count = 0.
- Boundary: second press starting exactly when the gap reaches 3 units → no char_done, and sym_count reaches 2.
